game_turn_ctrl: RTL
===================

# game_turn_ctrl

Parametrised turn-sequencing controller for the ChickenCHACHACHA board-game datapath. It accepts a player count from the keypad and rotates turns among 2..MAX_PLAYERS players. Each turn it waits for a key press, evaluates the guess, and either passes the turn, pulses a move, or declares a winner. A per-turn timeout and an abort input cover stalled or cancelled games.

## Interface
- MAX_PLAYERS, 4: maximum players accepted; must be ≥ MIN_PLAYERS and < 2^KEY_W.
- MIN_PLAYERS, 2: minimum players accepted.
- KEY_W, 4: keypad code width; code 0 means "no key".
- TIMEOUT, 255: WAIT_KEY cycles before a forced pass; 0 disables the timeout.
- TURN_W, 8: width of the turn counter.
- PW (localparam) = $clog2(MAX_PLAYERS+1).

Ports:
- clk in 1: single clock, rising edge.
- rst in 1: reset, synchronous, active-low.
- start in 1: leave IDLE; in DONE, begin a new game.
- key in KEY_W: keypad code, 0 = none.
- go in 1: sampled in EVAL; 1 = correct guess.
- win in 1: sampled in JUDGE; 1 = current player has won.
- abort in 1: return to IDLE from any state.
- state out 4: current state code.
- wait_key out 1: high while in WAIT_KEY.
- move out 1: high for the single MOVE cycle.
- timeout out 1: one-cycle pulse when a turn times out.
- num_players out PW: latched player count.
- cur_player out PW: active player, 0..num_players-1.
- turn_cnt out TURN_W: completed turn passes, saturating.
- winner out PW: player index latched on a win.
- game_over out 1: high in DONE.

## Operation
- State codes: IDLE=0, SETUP=1, INIT=2, WAIT_KEY=3, EVAL=4, PASS=5, MOVE=6, JUDGE=7, DONE=8. wait_key, move and game_over are Moore outputs decoded from the state register.
- Transition priority (highest first): rst low, then abort, then the state's own transition. abort in IDLE has no effect.
- IDLE:
  - num_players, cur_player, turn_cnt, winner and the timer are all 0.
  - start=1 → SETUP.
- SETUP:
  - If MIN_PLAYERS ≤ key ≤ MAX_PLAYERS: latch num_players ← key, go to INIT.
  - Otherwise stay; this includes key=0 and out-of-range codes.
- INIT:
  - Set cur_player←0, turn_cnt←0, timer←0, armed←0.
  - → WAIT_KEY.
- WAIT_KEY:
  - Internal `armed` flag: set when key==0 is seen. A key is accepted only if armed=1 and key≠0.
  - A held key therefore never triggers two turns.
  - On an accepted key: armed←0, timer←0, → EVAL.
  - Otherwise the timer increments each cycle.
  - If TIMEOUT≠0 and timer==TIMEOUT-1 with no accepted key: pulse timeout, timer←0, → PASS.
  - An accepted key in that same cycle wins over the timeout.
- EVAL: go=1 → MOVE; go=0 → PASS.
- PASS:
  - cur_player ← (cur_player==num_players-1) ? 0 : cur_player+1.
  - turn_cnt ← turn_cnt+1, saturating at 2^TURN_W-1.
  - → WAIT_KEY.
- MOVE: → JUDGE.
- JUDGE:
  - win=1: winner←cur_player, → DONE.
  - win=0: → WAIT_KEY; the same player keeps the turn.
- DONE:
  - Outputs hold.
  - start=1 → SETUP; game_over clears, and winner holds until the next INIT.
- Unused state codes (9..15) → IDLE on the next cycle.

## Timing
- Reset (rst=0 at an edge): state=IDLE, all outputs 0, timer=0, armed=0.
- Key latency: accepted key in WAIT_KEY at cycle n → EVAL at n+1.
  - go=1 path: MOVE at n+2 (move=1 that cycle only), JUDGE at n+3, DONE or WAIT_KEY at n+4.
  - go=0 path: PASS at n+2, WAIT_KEY at n+3 with the new cur_player visible.
- timeout and move are each exactly one cycle wide, aligned with the state transition edge.
- abort or rst asserted mid-turn (any state) takes effect at the next edge. No partial update of cur_player or turn_cnt occurs in that cycle.

## Test plan
- Reset and setup: hold rst=0 for 3 cycles, then release. Pulse start, then drive key=1, key=7, key=3. Required: state stays SETUP through 1 and 7; num_players=3 and INIT on the cycle after key=3.
- Rotation and wrap: num_players=3, four key presses each with go=0, key released between presses. Required: cur_player goes 0→1→2→0→1; turn_cnt=4.
- Held key: key=5 held for 20 cycles in WAIT_KEY with go=0. Required: exactly one EVAL/PASS; further passes only after key returns to 0.
- Timeout (TIMEOUT=8): no key. Required: timeout pulses after 8 WAIT_KEY cycles; cur_player advances; repeats every 9 cycles. The same bench with TIMEOUT=0 never pulses.
- Win path: player 1 presses a key, go=1, win=1 in JUDGE. Required: move high exactly one cycle; DONE with winner=1 and game_over=1; start then returns the block to SETUP.
- Abort/reset mid-turn: abort in MOVE. Required: IDLE next cycle, turn_cnt=0, move never re-asserts. rst=0 in EVAL gives the same IDLE result.

Source files
------------

// File: rtl/game_turn_ctrl.sv
// ---------------------------------------------------------------------------
// game_turn_ctrl
//   Turn-sequencing controller for the ChickenCHACHACHA board-game datapath.
//   Latches a player count from the keypad, then rotates turns among the
//   players. Each turn waits for a fresh key press, evaluates the guess
//   (go), and either passes the turn, pulses a move, or declares a winner.
//   A per-turn timeout forces a pass; abort returns to IDLE from any state.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous reset, active low
//   start       : leave IDLE / begin a new game from DONE
//   key         : keypad code, 0 = no key
//   go          : sampled in EVAL, 1 = correct guess
//   win         : sampled in JUDGE, 1 = current player has won
//   abort       : return to IDLE (no effect in IDLE)
//   state       : current state code
//   wait_key    : high in WAIT_KEY
//   move        : high for the single MOVE cycle
//   timeout     : one-cycle pulse when a turn times out (during PASS)
//   num_players : latched player count
//   cur_player  : active player index
//   turn_cnt    : completed turn passes, saturating
//   winner      : player index latched on a win
//   game_over   : high in DONE
// ---------------------------------------------------------------------------
module game_turn_ctrl #(
    parameter int MAX_PLAYERS = 4,
    parameter int MIN_PLAYERS = 2,
    parameter int KEY_W       = 4,
    parameter int TIMEOUT     = 255,
    parameter int TURN_W      = 8,
    localparam int PW         = $clog2(MAX_PLAYERS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic              go,
    input  logic              win,
    input  logic              abort,
    output logic [3:0]        state,
    output logic              wait_key,
    output logic              move,
    output logic              timeout,
    output logic [PW-1:0]     num_players,
    output logic [PW-1:0]     cur_player,
    output logic [TURN_W-1:0] turn_cnt,
    output logic [PW-1:0]     winner,
    output logic              game_over
);

    // Timer is wide enough to hold TIMEOUT-1 and never zero-width.
    localparam int TMR_W = $clog2(TIMEOUT + 2);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SETUP = 4'd1,
        S_INIT  = 4'd2,
        S_WAIT  = 4'd3,
        S_EVAL  = 4'd4,
        S_PASS  = 4'd5,
        S_MOVE  = 4'd6,
        S_JUDGE = 4'd7,
        S_DONE  = 4'd8
    } state_e;

    state_e             state_q;
    logic [PW-1:0]      num_players_q;
    logic [PW-1:0]      cur_player_q;
    logic [TURN_W-1:0]  turn_cnt_q;
    logic [PW-1:0]      winner_q;
    logic [TMR_W-1:0]   timer_q;
    logic               armed_q;
    logic               timeout_q;

    logic               clr;
    logic               key_ok;
    logic               key_acc;

    // Being in IDLE, aborting, or sitting in an unused code all collapse to
    // the same "everything zero" update; start from IDLE still wins because
    // abort is meaningless there.
    assign clr     = (state_q == S_IDLE) || abort || (state_q > S_DONE);
    assign key_ok  = (key >= KEY_W'(MIN_PLAYERS)) && (key <= KEY_W'(MAX_PLAYERS));
    // Armed only after a key==0 cycle, so a held key fires once per release.
    assign key_acc = armed_q && (key != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            num_players_q <= '0;
            cur_player_q  <= '0;
            turn_cnt_q    <= '0;
            winner_q      <= '0;
            timer_q       <= '0;
            armed_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (clr) begin
                num_players_q <= '0;
                cur_player_q  <= '0;
                turn_cnt_q    <= '0;
                winner_q      <= '0;
                timer_q       <= '0;
                armed_q       <= 1'b0;
                state_q       <= (state_q == S_IDLE && start) ? S_SETUP : S_IDLE;
            end else begin
                case (state_q)
                    S_SETUP: begin
                        if (key_ok) begin
                            num_players_q <= PW'(key);
                            state_q       <= S_INIT;
                        end
                    end
                    S_INIT: begin
                        cur_player_q <= '0;
                        turn_cnt_q   <= '0;
                        winner_q     <= '0;
                        timer_q      <= '0;
                        armed_q      <= 1'b0;
                        state_q      <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (key == '0) armed_q <= 1'b1;
                        if (key_acc) begin
                            armed_q <= 1'b0;
                            timer_q <= '0;
                            state_q <= S_EVAL;
                        end else if (TIMEOUT != 0 && timer_q == TMO_LAST) begin
                            timeout_q <= 1'b1;
                            timer_q   <= '0;
                            state_q   <= S_PASS;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    S_EVAL:  state_q <= go ? S_MOVE : S_PASS;
                    S_PASS: begin
                        cur_player_q <= (cur_player_q == num_players_q - PW'(1))
                                        ? '0 : cur_player_q + PW'(1);
                        if (turn_cnt_q != {TURN_W{1'b1}})
                            turn_cnt_q <= turn_cnt_q + TURN_W'(1);
                        state_q <= S_WAIT;
                    end
                    S_MOVE:  state_q <= S_JUDGE;
                    S_JUDGE: begin
                        if (win) begin
                            winner_q <= cur_player_q;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_WAIT;
                        end
                    end
                    S_DONE: begin
                        if (start) state_q <= S_SETUP;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign state       = state_q;
    assign wait_key    = (state_q == S_WAIT);
    assign move        = (state_q == S_MOVE);
    assign game_over   = (state_q == S_DONE);
    assign timeout     = timeout_q;
    assign num_players = num_players_q;
    assign cur_player  = cur_player_q;
    assign turn_cnt    = turn_cnt_q;
    assign winner      = winner_q;

endmodule
